array_mult_bank: RTL

Shared six-lane signed fixed-point multiplier bank that serves the multiply requests issued by the DH transform block of the full-Jacobian datapath. It is the responder on the `array_mult_dataa` / `array_mult_datab` / `array_mult_result` interface. The bank samples six operand pairs per enabled cycle, tags them with the requester's `count`, and returns rounded, saturated products a fixed number of enabled cycles later. The requester schedules its own matrix-element arithmetic around that fixed latency.

---
 rtl/fixed_pkg.sv | 17 +
 rtl/mult_lane.sv | 116 +++++++++++
 rtl/array_mult_bank.sv | 78 +++++++
 3 files changed

// File: rtl/fixed_pkg.sv
// fixed_pkg
// Shared Q15.20 signed fixed-point definitions for the full-Jacobian datapath.
// Used by the multiplier bank and by the DH transform block that drives it.
// No ports; provides the format width, fractional bit count, the fix_t type
// and the one / max / min constants.
package fixed_pkg;

    localparam int FIX_WIDTH = 36;
    localparam int FIX_FRAC  = 20;

    typedef logic signed [35:0] fix_t;

    localparam fix_t FIX_ONE = 36'sh0_0010_0000;
    localparam fix_t FIX_MAX = 36'sh7_FFFF_FFFF;
    localparam fix_t FIX_MIN = 36'sh8_0000_0000;

endpackage

// File: rtl/mult_lane.sv
// mult_lane
// One signed fixed-point multiplier lane: sat(round(a*b >> FRAC)).
// Stage S1 registers the operands, S2 the full-width product, the optional
// delay stages S3..S(LATENCY-1) carry the rounded product, and the final
// stage registers the saturated result. Every register holds while en=0 and
// clears on rst (rst wins over en).
// Ports:
//   clk, rst, en   clock, synchronous active-high reset, advance enable
//   dataa, datab   multiplicand / multiplier, signed WIDTH bits
//   result         registered rounded and saturated product
module mult_lane
    import fixed_pkg::*;
#(
    parameter int WIDTH   = FIX_WIDTH,
    parameter int FRAC    = FIX_FRAC,
    parameter int LATENCY = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] dataa,
    input  logic [WIDTH-1:0] datab,
    output logic [WIDTH-1:0] result
);

    localparam int PW = 2 * WIDTH;
    localparam int ND = LATENCY - 3;
    localparam logic signed [PW-1:0] RND_HALF = {{(PW-1){1'b0}}, 1'b1} << (FRAC - 1);

    // Arithmetic shift by FRAC, then clamp to the WIDTH-bit signed range.
    // The value fits iff every bit above the result sign equals the sign.
    function automatic logic [WIDTH-1:0] sat_shift(input logic signed [PW-1:0] v);
        logic signed [PW-1:0] sh;
        logic [WIDTH-1:0]     res;
        sh = v >>> FRAC;
        if (!sh[PW-1] && (|sh[PW-2:WIDTH-1])) begin
            res = {1'b0, {(WIDTH-1){1'b1}}};
        end else if (sh[PW-1] && !(&sh[PW-2:WIDTH-1])) begin
            res = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            res = sh[WIDTH-1:0];
        end
        return res;
    endfunction

    logic signed [WIDTH-1:0] a_r;
    logic signed [WIDTH-1:0] b_r;
    logic signed [PW-1:0]    prod_r;
    logic signed [PW-1:0]    a_ext_s;
    logic signed [PW-1:0]    b_ext_s;
    logic signed [PW-1:0]    rnd_s;
    logic [WIDTH-1:0]        result_r;

    assign a_ext_s = {{WIDTH{a_r[WIDTH-1]}}, a_r};
    assign b_ext_s = {{WIDTH{b_r[WIDTH-1]}}, b_r};

    // S1 operand capture and S2 full-width product.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r    <= {WIDTH{1'b0}};
            b_r    <= {WIDTH{1'b0}};
            prod_r <= {PW{1'b0}};
        end else if (en) begin
            a_r    <= dataa;
            b_r    <= datab;
            prod_r <= a_ext_s * b_ext_s;
        end else begin
            a_r    <= a_r;
            b_r    <= b_r;
            prod_r <= prod_r;
        end
    end

    generate
        if (ND > 0) begin : g_delay
            logic signed [PW-1:0] dly_r [ND];

            // Delay stages; the first one also applies the half-LSB rounding add.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < ND; i++) begin
                        dly_r[i] <= {PW{1'b0}};
                    end
                end else if (en) begin
                    dly_r[0] <= prod_r + RND_HALF;
                    for (int i = 1; i < ND; i++) begin
                        dly_r[i] <= dly_r[i-1];
                    end
                end else begin
                    for (int i = 0; i < ND; i++) begin
                        dly_r[i] <= dly_r[i];
                    end
                end
            end

            assign rnd_s = dly_r[ND-1];
        end else begin : g_nodelay
            // With the minimum latency the rounding add folds into the last stage.
            assign rnd_s = prod_r + RND_HALF;
        end
    endgenerate

    // Final stage: registered saturated result.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_r <= {WIDTH{1'b0}};
        end else if (en) begin
            result_r <= sat_shift(rnd_s);
        end else begin
            result_r <= result_r;
        end
    end

    assign result = result_r;

endmodule

// File: rtl/array_mult_bank.sv
// array_mult_bank
// Six-lane (LANES) signed Q15.20 multiplier bank serving the DH transform
// block. Each enabled cycle is one request: six operand pairs plus a tag.
// Rounded, saturated products and the tag return LATENCY enabled cycles later.
// en=0 freezes the whole pipeline; rst (synchronous, active-high, priority
// over en) clears outputs and discards in-flight requests.
// Ports:
//   clk, rst, en        clock, reset, advance enable
//   count               8-bit requester tag sampled with the operands
//   array_mult_dataa/b  per-lane multiplicand / multiplier
//   array_mult_result   per-lane registered products
//   result_count        tag of the current result
//   result_valid        result came through the pipeline since last reset
module array_mult_bank
    import fixed_pkg::*;
#(
    parameter int LANES   = 6,
    parameter int WIDTH   = FIX_WIDTH,
    parameter int FRAC    = FIX_FRAC,
    parameter int LATENCY = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [7:0]                   count,
    input  logic [LANES-1:0][WIDTH-1:0]  array_mult_dataa,
    input  logic [LANES-1:0][WIDTH-1:0]  array_mult_datab,
    output logic [LANES-1:0][WIDTH-1:0]  array_mult_result,
    output logic [7:0]                   result_count,
    output logic                         result_valid
);

    logic [LATENCY-1:0] vld_r;
    logic [7:0]         tag_r [LATENCY];

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            mult_lane #(
                .WIDTH   (WIDTH),
                .FRAC    (FRAC),
                .LATENCY (LATENCY)
            ) u_lane (
                .clk    (clk),
                .rst    (rst),
                .en     (en),
                .dataa  (array_mult_dataa[g]),
                .datab  (array_mult_datab[g]),
                .result (array_mult_result[g])
            );
        end
    endgenerate

    // Valid/tag chain that runs in lockstep with the lane pipelines.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_r <= {LATENCY{1'b0}};
            for (int i = 0; i < LATENCY; i++) begin
                tag_r[i] <= 8'h00;
            end
        end else if (en) begin
            vld_r    <= {vld_r[LATENCY-2:0], 1'b1};
            tag_r[0] <= count;
            for (int i = 1; i < LATENCY; i++) begin
                tag_r[i] <= tag_r[i-1];
            end
        end else begin
            vld_r <= vld_r;
            for (int i = 0; i < LATENCY; i++) begin
                tag_r[i] <= tag_r[i];
            end
        end
    end

    assign result_valid = vld_r[LATENCY-1];
    assign result_count = tag_r[LATENCY-1];

endmodule
